// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, sequencer states and IR field positions for the Mini SRC control unit
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_HALT  = 4'd7,
        S_FAULT = 4'd8
    } state_t;

    function automatic logic is_three_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL, OP_MUL, OP_DIV: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Bit order matches {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,MUL,DIV,NEG,NOT}
    function automatic logic [12:0] alu_onehot(input logic [4:0] op);
        case (op)
            OP_ADD:  return 13'b1_0000_0000_0000;
            OP_SUB:  return 13'b0_1000_0000_0000;
            OP_AND:  return 13'b0_0100_0000_0000;
            OP_OR:   return 13'b0_0010_0000_0000;
            OP_SHR:  return 13'b0_0001_0000_0000;
            OP_SHRA: return 13'b0_0000_1000_0000;
            OP_SHL:  return 13'b0_0000_0100_0000;
            OP_ROR:  return 13'b0_0000_0010_0000;
            OP_ROL:  return 13'b0_0000_0001_0000;
            OP_MUL:  return 13'b0_0000_0000_1000;
            OP_DIV:  return 13'b0_0000_0000_0100;
            OP_NEG:  return 13'b0_0000_0000_0010;
            OP_NOT:  return 13'b0_0000_0000_0001;
            default: return 13'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 4-bit register field to gated one-hot 16-bit select
module reg_select_decoder (
    input  logic [3:0]  field,
    input  logic        en,
    output logic [15:0] onehot
);

    assign onehot = en ? (16'd1 << field) : 16'd0;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute control unit for the Mini SRC datapath
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        MemRdy,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        R0out,  output logic R1out,  output logic R2out,  output logic R3out,
    output logic        R4out,  output logic R5out,  output logic R6out,  output logic R7out,
    output logic        R8out,  output logic R9out,  output logic R10out, output logic R11out,
    output logic        R12out, output logic R13out, output logic R14out, output logic R15out,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        MARin,
    output logic        MDRin,
    output logic        R0in,  output logic R1in,  output logic R2in,  output logic R3in,
    output logic        R4in,  output logic R5in,  output logic R6in,  output logic R7in,
    output logic        R8in,  output logic R9in,  output logic R10in, output logic R11in,
    output logic        R12in, output logic R13in, output logic R14in, output logic R15in,
    output logic        IncPC,
    output logic        Read,
    output logic        ADD, output logic SUB,  output logic AND, output logic OR,
    output logic        SHR, output logic SHRA, output logic SHL, output logic ROR,
    output logic        ROL, output logic MUL,  output logic DIV, output logic NEG,
    output logic        NOT,
    output logic        Run,
    output logic        Fault
);

    state_t      state;
    logic [4:0]  opcode;
    logic        three;
    logic        unary;
    logic        ra_en, rb_en, rc_en;
    logic [15:0] ra_vec, rb_vec, rc_vec;
    logic [15:0] r_out_vec;
    logic [12:0] alu_vec;
    logic        unused_ir;

    assign opcode    = IR[OPC_MSB:OPC_LSB];
    assign three     = is_three_op(opcode);
    assign unary     = is_unary(opcode);
    assign unused_ir = ^IR[RC_LSB-1:0];

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST: state <= S_T0;
                S_T0:  state <= S_T1;
                S_T1:  if (MemRdy) state <= S_T2;
                S_T2: begin
                    if (opcode == OP_NOP)       state <= S_T0;
                    else if (opcode == OP_HALT) state <= S_HALT;
                    else if (three || unary)    state <= S_T3;
                    else                        state <= S_FAULT;
                end
                S_T3:    state <= S_T4;
                S_T4:    state <= unary ? S_T0 : S_T5;
                S_T5:    state <= S_T0;
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_RST;
            endcase
        end
    end

    // Rb drives the bus in T3 for both op classes, Rc only in T4 of three-operand ops
    assign rb_en = (state == S_T3) && (three || unary);
    assign rc_en = (state == S_T4) && three;
    assign ra_en = ((state == S_T5) && three) || ((state == S_T4) && unary);

    reg_select_decoder u_ra_in  (.field(IR[RA_MSB:RA_LSB]), .en(ra_en), .onehot(ra_vec));
    reg_select_decoder u_rb_out (.field(IR[RB_MSB:RB_LSB]), .en(rb_en), .onehot(rb_vec));
    reg_select_decoder u_rc_out (.field(IR[RC_MSB:RC_LSB]), .en(rc_en), .onehot(rc_vec));

    assign r_out_vec = rb_vec | rc_vec;

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        PCin    = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        alu_vec = 13'b0;
        Run     = (state != S_HALT) && (state != S_FAULT);
        Fault   = (state == S_FAULT);
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (three) begin
                    Yin = 1'b1;
                end else if (unary) begin
                    alu_vec = alu_onehot(opcode);
                    Zin     = 1'b1;
                end
            end
            S_T4: begin
                if (three) begin
                    alu_vec = alu_onehot(opcode);
                    Zin     = 1'b1;
                end else if (unary) begin
                    Zlowout = 1'b1;
                end
            end
            S_T5:    Zlowout = 1'b1;
            default: ;
        endcase
    end

    assign {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT} = alu_vec;

    assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
            R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out} = r_out_vec;

    assign {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
            R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in} = ra_vec;

endmodule
